// File: rtl/issue_scheduler.sv
// Age-ordered issue scheduler: each cycle, every execution unit with a free
// slot takes the oldest ready entry aimed at it and holds its tag until accepted.
module issue_scheduler #(
    parameter int ROB_SIZE  = 16,
    parameter int TAG_WIDTH = 4,
    parameter int NUM_UNITS = 4,
    parameter int UID_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            halt,
    input  logic [ROB_SIZE-1:0]             req_valid,
    input  logic [ROB_SIZE*UID_WIDTH-1:0]   req_unit,
    input  logic [TAG_WIDTH-1:0]            head,
    output logic [ROB_SIZE-1:0]             grant,
    output logic [NUM_UNITS-1:0]            issue_valid,
    output logic [NUM_UNITS*TAG_WIDTH-1:0]  issue_tag,
    input  logic [NUM_UNITS-1:0]            issue_ready,
    output logic [15:0]                     issued_count
);

    logic [UID_WIDTH-1:0] unit_of   [ROB_SIZE];
    logic [NUM_UNITS-1:0] slot_free;
    logic [NUM_UNITS-1:0] cand_found;
    logic [TAG_WIDTH-1:0] cand_tag  [NUM_UNITS];
    logic [NUM_UNITS-1:0] handshake;
    logic [15:0]          hs_count;
    logic                 grant_en;

    assign grant_en  = !rst && !halt && !flush;
    assign slot_free = ~issue_valid | issue_ready;
    assign handshake = issue_valid & issue_ready;

    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            unit_of[i] = req_unit[i*UID_WIDTH +: UID_WIDTH];
        end
    end

    // Walk entries from head outward so the first hit per unit is the oldest;
    // unit fields >= NUM_UNITS never match any unit index.
    always_comb begin
        logic [TAG_WIDTH-1:0] idx;
        idx        = '0;
        cand_found = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            cand_tag[u] = '0;
            for (int k = 0; k < ROB_SIZE; k++) begin
                idx = head + TAG_WIDTH'(k);
                if (!cand_found[u] && req_valid[idx] && unit_of[idx] == UID_WIDTH'(u)) begin
                    cand_found[u] = 1'b1;
                    cand_tag[u]   = idx;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (grant_en && slot_free[u] && cand_found[u]) begin
                grant[cand_tag[u]] = 1'b1;
            end
        end
    end

    always_comb begin
        hs_count = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            hs_count = hs_count + 16'(handshake[u]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid  <= '0;
            issue_tag    <= '0;
            issued_count <= '0;
        end else if (flush) begin
            issue_valid  <= '0;
            issued_count <= issued_count + hs_count;
        end else if (!halt) begin
            issued_count <= issued_count + hs_count;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (slot_free[u]) begin
                    if (cand_found[u]) begin
                        issue_valid[u]                       <= 1'b1;
                        issue_tag[u*TAG_WIDTH +: TAG_WIDTH]  <= cand_tag[u];
                    end else if (handshake[u]) begin
                        issue_valid[u] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter ROB_SIZE, default 16, number of buffer entries competing for issue.
REQ-002 Parameter TAG_WIDTH, default 4, entry index width; SHALL equal clog2(ROB_SIZE).
REQ-003 Parameter NUM_UNITS, default 4, number of execution units.
REQ-004 Parameter UID_WIDTH, default 2, execution-unit index width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  discard all held issues; no grants this cycle.
REQ-008 halt  input  1  freeze: no grants, all registers hold.
REQ-009 req_valid  input  ROB_SIZE  bit i = entry i operands ready and not yet dispatched.
REQ-010 req_unit  input  ROB_SIZE*UID_WIDTH  target unit of entry i at bits [i*UID_WIDTH +: UID_WIDTH].
REQ-011 head  input  TAG_WIDTH  index of oldest entry (age origin).
REQ-012 grant  output  ROB_SIZE  combinational; bit i = entry i accepted this cycle (buffer sets its dispatched flag at the edge).
REQ-013 issue_valid  output  NUM_UNITS  registered; bit u = issue slot u holds a valid tag.
REQ-014 issue_tag  output  NUM_UNITS*TAG_WIDTH  registered; tag for unit u at bits [u*TAG_WIDTH +: TAG_WIDTH].
REQ-015 issue_ready  input  NUM_UNITS  unit u accepts its slot when issue_valid[u] & issue_ready[u].
REQ-016 issued_count  output  16  registered count of completed unit handshakes, wraps at 65535->0.

Function
REQ-017 Age of entry i SHALL be (i - head) mod ROB_SIZE; smaller age = older.
REQ-018 Candidate set for unit u SHALL be entries with req_valid[i]=1 and req_unit field = u; req_unit >= NUM_UNITS SHALL never be granted.
REQ-019 Slot u SHALL be free when issue_valid[u]=0 or issue_ready[u]=1 (full-throughput, no bubble).
REQ-020 When slot u is free, halt=0, flush=0: the oldest candidate for u SHALL be granted; grant[i]=1 same cycle; at the edge issue_tag[u]<=i, issue_valid[u]<=1.
REQ-021 At most one grant per unit per cycle; up to NUM_UNITS grants per cycle across units; one entry SHALL never receive two grants.
REQ-022 Slot free with no candidate: issue_valid[u]<=0 at edge if handshake occurred, otherwise unchanged.
REQ-023 Slot u not free (valid, not ready): issue_valid[u], issue_tag[u] SHALL hold; no grant for unit u.
REQ-024 Age wrap-around: head=14 with entries 15 and 1 ready for same unit -> 15 granted (age 1 < age 3).
REQ-025 halt=1: grant=0; issue_valid, issue_tag, issued_count hold; issue_ready ignored.
REQ-026 flush=1 (halt=0): grant=0; at edge issue_valid<=0; issued_count SHALL still count handshakes completing that cycle.
REQ-027 flush and halt both 1: flush SHALL take priority.
REQ-028 issued_count SHALL increase by the number of units with issue_valid & issue_ready in the cycle (halt=0).
REQ-029 Latency: grant in cycle N -> issue_valid visible cycle N+1.

Reset
REQ-030 rst=1 at an edge: issue_valid=0, issue_tag=0, issued_count=0; grant=0 while rst=1; rst SHALL override halt and flush.
REQ-031 Reset mid-handshake SHALL drop held issues without counting them.

Verification
REQ-032 Reset, req_valid=0 -> grant=0, issue_valid=0, issued_count=0 for 5 cycles.
REQ-033 head=0, req_valid=0x0006, both unit 2, issue_ready=0xF -> cycle 1 grant=0x0002, cycle 2 issue_tag[2]=1; then grant=0x0004 (entry 1 cleared), issue_tag[2]=2.
REQ-034 head=14, entries 15,1 ready for unit 0 -> grant=0x8000, issue_tag[0]=15.
REQ-035 Entries 3,4,5,6 targeting units 0,1,2,3 -> grant=0x0078 one cycle; next cycle issue_valid=0xF; issued_count +4 following cycle.
REQ-036 issue_valid[1]=1 tag 5, issue_ready[1]=0, entry 9 ready for unit 1 -> grant[9]=0, tag held 5; raise ready -> grant[9]=1, next tag 9.
REQ-037 issue_valid=0xF, assert flush -> grant=0, next cycle issue_valid=0; assert halt -> all outputs frozen.
